// File: rtl/hazard_sb.sv
// hazard_sb - scoreboard hazard and pipeline-control unit for the five-stage core.
//
// Each architectural register (except r0) owns a small down-counter holding the
// number of cycles until its pending result becomes forwardable. A D-stage
// instruction stalls while any register it reads still has a nonzero count.
// This handles results of any latency (ALU, load, multi-cycle mul/div), not
// only the load-use case.
//
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   i_stall, d_stall         instruction / data memory not ready
//   div_stallE               multi-cycle divider busy
//   is_exceptM               exception taken in M; flushes the whole pipe
//   issue_valid              a valid instruction sits in D
//   rs_d/rt_d, rs_use/rt_use D-stage sources and whether they are read
//   rd_d, rd_we, rd_lat      D-stage destination, write enable, result latency
//   stall{F,D,E,M,W}         stage hold
//   flush{F,D,E,M,W}         stage bubble
//   longest_stall            any global freeze source
//   data_stall_cyc           data-hazard stall cycles (performance build only)
//   freeze_cyc               freeze cycles (performance build only)
//
// Build option: define HAZARD_SB_PERF_EN to build the two saturating
// performance counters. Without it both counter outputs are tied to 0.

module hazard_sb #(
  parameter int REG_AW = 5,
  parameter int LAT_W  = 3,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_stall,
  input  logic              d_stall,
  input  logic              div_stallE,
  input  logic              is_exceptM,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic              rs_use,
  input  logic              rt_use,
  input  logic [REG_AW-1:0] rd_d,
  input  logic              rd_we,
  input  logic [LAT_W-1:0]  rd_lat,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              stallW,
  output logic              flushF,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              flushW,
  output logic              longest_stall,
  output logic [CNT_W-1:0]  data_stall_cyc,
  output logic [CNT_W-1:0]  freeze_cyc
);

  localparam int NREG = 2 ** REG_AW;

  // r0 is hardwired to zero, so it has no counter and is never busy.
  logic [LAT_W-1:0] cnt_q [NREG-1:1];
  logic [LAT_W-1:0] cnt_d [NREG-1:1];
  logic [NREG-1:0]  busy;
  logic             hz;
  logic             data_stall;
  logic             issue;

  always_comb begin
    busy = '0;
    for (int r = 1; r < NREG; r++) begin
      busy[r] = (cnt_q[r] != '0);
    end
  end

  assign longest_stall = i_stall | d_stall | div_stallE;
  assign hz            = issue_valid & ((rs_use & busy[rs_d]) | (rt_use & busy[rt_d]));
  assign data_stall    = hz & ~longest_stall;

  assign stallD = hz | longest_stall;
  assign stallF = stallD & ~is_exceptM;
  assign stallE = longest_stall;
  assign stallM = longest_stall;
  assign stallW = longest_stall & ~is_exceptM;

  assign flushE = data_stall | is_exceptM;
  assign flushF = is_exceptM;
  assign flushD = is_exceptM;
  assign flushM = is_exceptM;
  assign flushW = is_exceptM;

  assign issue = issue_valid & ~stallD & rd_we & (rd_d != '0);

  // Exception wipes every pending result; a freeze holds all counts; otherwise
  // counts drain by one and a new issue reloads its destination (the reload
  // wins over the decrement, so the newest writer's latency is what counts).
  always_comb begin
    for (int r = 1; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (is_exceptM) begin
        cnt_d[r] = '0;
      end else if (!longest_stall) begin
        if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - LAT_W'(1);
        if (issue && (rd_d == REG_AW'(r))) cnt_d[r] = rd_lat;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 1; r < NREG; r++) begin
      if (rst) cnt_q[r] <= '0;
      else     cnt_q[r] <= cnt_d[r];
    end
  end

`ifdef HAZARD_SB_PERF_EN
  logic [CNT_W-1:0] data_stall_cyc_q, data_stall_cyc_d;
  logic [CNT_W-1:0] freeze_cyc_q, freeze_cyc_d;

  // Saturating counters; only rst clears them so exceptions do not lose history.
  always_comb begin
    data_stall_cyc_d = data_stall_cyc_q;
    freeze_cyc_d     = freeze_cyc_q;
    if (data_stall && (data_stall_cyc_q != '1)) data_stall_cyc_d = data_stall_cyc_q + CNT_W'(1);
    if (longest_stall && (freeze_cyc_q != '1))  freeze_cyc_d     = freeze_cyc_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_stall_cyc_q <= '0;
      freeze_cyc_q     <= '0;
    end else begin
      data_stall_cyc_q <= data_stall_cyc_d;
      freeze_cyc_q     <= freeze_cyc_d;
    end
  end

  assign data_stall_cyc = data_stall_cyc_q;
  assign freeze_cyc     = freeze_cyc_q;
`else
  assign data_stall_cyc = '0;
  assign freeze_cyc     = '0;
`endif

endmodule

// File: doc/hazard_sb.md
# hazard_sb

Scoreboard-based hazard and pipeline-control unit for the five-stage MIPS core. It is the parametrised successor of the combinational hazard unit. Instead of comparing stage register addresses, it keeps a per-register countdown of cycles until a pending result becomes forwardable. Decode-stage stalls therefore work for arbitrary result latencies (ALU, load, multi-cycle div/mul), not just the load-use case. The block sits beside the datapath, takes decode operand info and global freeze/exception inputs, and produces all stall and flush signals.

## Interface
Parameters:
- REG_AW, 5, register-address width; tracks 2**REG_AW registers, register 0 is never tracked
- LAT_W, 3, width of the per-register latency counter; maximum latency is 2**LAT_W-1
- CNT_W, 32, width of the performance counters

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- i_stall  input  1  instruction-side memory not ready
- d_stall  input  1  data-side memory not ready
- div_stallE  input  1  multi-cycle divider busy
- is_exceptM  input  1  exception taken in M; flushes the pipe
- issue_valid  input  1  a valid instruction is in D
- rs_d, rt_d  input  REG_AW  D-stage source registers
- rs_use, rt_use  input  1  the source is actually read
- rd_d  input  REG_AW  D-stage destination register
- rd_we  input  1  the D instruction writes rd_d
- rd_lat  input  LAT_W  cycles after issue before rd_d is forwardable; 0 means forwardable to the next instruction with no stall
- stallF, stallD, stallE, stallM, stallW  output  1  stage hold
- flushF, flushD, flushE, flushM, flushW  output  1  stage bubble
- longest_stall  output  1  i_stall | d_stall | div_stallE
- data_stall_cyc  output  CNT_W  count of data-hazard stall cycles (see Configuration)
- freeze_cyc  output  CNT_W  count of longest_stall cycles (see Configuration)

## Operation
- State: cnt[r] (LAT_W bits) for r = 1..2**REG_AW-1. r is busy when cnt[r] != 0.
- Hazard: hz = issue_valid & ((rs_use & rs_d!=0 & cnt[rs_d]!=0) | (rt_use & rt_d!=0 & cnt[rt_d]!=0)).
- Data stall: data_stall = hz & ~longest_stall.
- Stall outputs:
  - stallD = hz | longest_stall
  - stallF = stallD & ~is_exceptM
  - stallE = stallM = longest_stall
  - stallW = longest_stall & ~is_exceptM
- Flush outputs:
  - flushE = data_stall | is_exceptM
  - flushF = flushD = flushM = flushW = is_exceptM
- Issue event: issue_valid & ~stallD & rd_we & rd_d!=0.
- Counter update each cycle, in priority order:
  1. rst: all cnt to 0.
  2. is_exceptM: all cnt to 0. In-flight producers are flushed and W has completed.
  3. longest_stall: all cnt hold; no issue is possible.
  4. Otherwise: each nonzero cnt decrements by 1. On an issue event, cnt[rd_d] loads rd_lat. The load overrides the decrement for the same register.
- A later writer of the same register overwrites its count (WAW: newest latency wins).
- Counters never underflow; 0 stays 0.
- All stall/flush outputs are combinational from inputs and the registered cnt. There is no added latency.

## Timing
- Reset: cnt all 0. With all inputs 0 every stall/flush output is 0. Perf counters are 0.
- An issue with rd_lat=L at cycle t stalls a dependent instruction in D during cycles t+1..t+L. The dependent instruction issues at t+L+1, assuming no freeze.
- Freeze cycles extend that window 1:1.
- is_exceptM together with hz: flushes dominate, stallF=0, and cnt clears on the next edge.
- rst asserted mid-stall: cnt clears on the next edge regardless of the other inputs.
- Issue to a register whose cnt is already nonzero with rd_lat=0: cnt becomes 0 on the next edge.

## Configuration
- HAZARD_SB_PERF_EN defined:
  - data_stall_cyc increments on each cycle with data_stall=1.
  - freeze_cyc increments on each cycle with longest_stall=1.
  - Both saturate at all-ones and clear on rst only. They do not clear on exception.
- HAZARD_SB_PERF_EN undefined: both outputs are constant 0 and no counter flops are built.

## Test plan
- Reset, then idle inputs -> all stall/flush outputs 0, all cnt 0.
- Issue rd=8, rd_lat=2 at t; next instruction rs_d=8, rs_use=1 -> stallD=flushE=1 at t+1 and t+2, stallD=0 at t+3.
- Same as the previous case but d_stall=1 at t+1 -> stallE=stallM=stallW=1, flushE=0 at t+1, cnt[8] holds; release at t+4.
- rd_lat=3 issue to r5, then is_exceptM=1 next cycle -> all five flushes=1, stallF=0; cnt[5]=0 on the next cycle so a reader of r5 does not stall.
- Dependent on r0 after an issue with rd_d=0 -> no stall. Issue rd=9 lat=3 followed by rd=9 lat=0 -> reader of r9 does not stall.
- With HAZARD_SB_PERF_EN: 2 data-stall cycles plus 3 freeze cycles -> data_stall_cyc=2, freeze_cyc=3. Without the macro -> both outputs read 0.
